// File: rtl/display_pkg.sv
// display_pkg: shared FSM state encoding, mode indices and default limits
// for the display mode controller.
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } conv_state_t;

    localparam int c_mode_speed    = 0;
    localparam int c_mode_distance = 1;
    localparam int c_mode_clock    = 2;
    localparam int c_mode_average  = 3;

    localparam int c_def_num_modes       = 4;
    localparam int c_def_speed_width     = 12;
    localparam int c_def_overspeed_limit = 65;
    localparam int c_def_stop_limit      = 6;
    localparam int c_def_col_mode        = c_mode_clock;

    localparam int c_scroll_secs = 5;

endpackage

`default_nettype wire

// File: rtl/display_mode_ctrl_if.sv
// display_mode_ctrl_if: button/tick/speed/converter inputs and display outputs
// of the display mode controller, with master (driver) and slave (DUT) views.
`default_nettype none

interface display_mode_ctrl_if
    import display_pkg::*;
#(
    parameter int NUM_MODES   = c_def_num_modes,
    parameter int SPEED_WIDTH = c_def_speed_width
);
    localparam int SEL_W = $clog2(NUM_MODES);

    logic                   mode;
    logic                   half_sec_pulse;
    logic                   sec_pulse;
    logic [SPEED_WIDTH-1:0] speed;
    logic                   conv_valid;
    logic [SEL_W-1:0]       mode_sel;
    logic [NUM_MODES-1:0]   mode_lamp;
    logic                   conv_start;
    logic                   disp_load;
    logic                   point;
    logic                   col;
    logic                   en_accum;

    modport master (
        output mode, half_sec_pulse, sec_pulse, speed, conv_valid,
        input  mode_sel, mode_lamp, conv_start, disp_load, point, col, en_accum
    );

    modport slave (
        input  mode, half_sec_pulse, sec_pulse, speed, conv_valid,
        output mode_sel, mode_lamp, conv_start, disp_load, point, col, en_accum
    );

endinterface

`default_nettype wire

// File: rtl/conv_req_arbiter.sv
// conv_req_arbiter: turns request pulses into single converter handshakes,
// holding at most one request that arrives while a conversion is in flight.
`default_nettype none

module conv_req_arbiter
    import display_pkg::*;
(
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_req,
    input  wire logic i_conv_valid,
    output logic      o_conv_start,
    output logic      o_disp_load
);

    conv_state_t r_state;
    logic        r_pending;
    logic        r_conv_start;
    logic        r_disp_load;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_conv_start <= 1'b0;
            r_disp_load  <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            r_disp_load  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_state      <= ST_REQ;
                        r_conv_start <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                    if (i_req) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_conv_valid) begin
                        r_disp_load <= 1'b1;
                        // A request landing on the completion cycle is served like a pending one
                        if (r_pending || i_req) begin
                            r_state      <= ST_REQ;
                            r_conv_start <= 1'b1;
                            r_pending    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (i_req) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_conv_start = r_conv_start;
    assign o_disp_load  = r_disp_load;

endmodule

`default_nettype wire

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: mode cycling, lamp blinking, segment control and converter
// request generation. Optional DISPLAY_AUTO_SCROLL_EN advances the mode every 5 idle seconds.
`default_nettype none

module display_mode_ctrl
    import display_pkg::*;
#(
    parameter int NUM_MODES       = c_def_num_modes,
    parameter int SPEED_WIDTH     = c_def_speed_width,
    parameter int OVERSPEED_LIMIT = c_def_overspeed_limit,
    parameter int STOP_LIMIT      = c_def_stop_limit,
    parameter int COL_MODE        = c_def_col_mode
)(
    input  wire logic           clock,
    input  wire logic           reset,
    display_mode_ctrl_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_MODES);
    localparam logic [SEL_W-1:0] c_last_mode = SEL_W'(NUM_MODES - 1);
    localparam logic [SEL_W-1:0] c_col_mode  = SEL_W'(COL_MODE);

    logic [SEL_W-1:0]     r_mode_sel;
    logic                 r_blink;
    logic [NUM_MODES-1:0] r_lamp;
    logic                 r_en_accum;
    logic                 r_point;
    logic                 r_col;
    logic                 r_mode_req;

    logic                 w_mode_pulse;
    logic [SEL_W-1:0]     w_mode_next;
    logic                 w_overspeed;
    logic                 w_moving;
    logic                 w_req;
    logic [NUM_MODES-1:0] w_lamp_next;

`ifdef DISPLAY_AUTO_SCROLL_EN
    logic [2:0] r_scroll_cnt;
    logic       w_scroll;

    assign w_scroll = bus.sec_pulse && !bus.mode && (r_scroll_cnt == 3'(c_scroll_secs - 1));

    always_ff @(posedge clock) begin
        if (reset || bus.mode || w_scroll) begin
            r_scroll_cnt <= 3'd0;
        end else if (bus.sec_pulse) begin
            r_scroll_cnt <= r_scroll_cnt + 3'd1;
        end
    end

    assign w_mode_pulse = bus.mode | w_scroll;
`else
    assign w_mode_pulse = bus.mode;
`endif

    assign w_mode_next = (r_mode_sel == c_last_mode) ? '0 : r_mode_sel + SEL_W'(1);
    assign w_overspeed = bus.speed > SPEED_WIDTH'(OVERSPEED_LIMIT);
    assign w_moving    = bus.speed >= SPEED_WIDTH'(STOP_LIMIT);
    // A mode pulse coinciding with sec_pulse is already covered by that request
    assign w_req       = bus.sec_pulse | r_mode_req;

    always_comb begin
        w_lamp_next = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            w_lamp_next[i] = (r_mode_sel == SEL_W'(i)) | (w_overspeed & r_blink);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode_sel <= '0;
            r_blink    <= 1'b0;
            r_lamp     <= '0;
            r_en_accum <= 1'b0;
            r_point    <= 1'b0;
            r_col      <= 1'b0;
            r_mode_req <= 1'b0;
        end else begin
            r_blink    <= r_blink ^ bus.half_sec_pulse;
            r_lamp     <= w_lamp_next;
            r_en_accum <= w_moving;
            r_mode_req <= w_mode_pulse & ~bus.sec_pulse;
            if (w_mode_pulse) begin
                r_mode_sel <= w_mode_next;
                r_col      <= 1'b0;
                r_point    <= (w_mode_next < c_col_mode);
            end else if (bus.sec_pulse) begin
                r_point <= (r_mode_sel < c_col_mode);
                r_col   <= (r_mode_sel == c_col_mode) ? ~r_col : 1'b0;
            end
        end
    end

    conv_req_arbiter u_arbiter (
        .clock        (clock),
        .reset        (reset),
        .i_req        (w_req),
        .i_conv_valid (bus.conv_valid),
        .o_conv_start (bus.conv_start),
        .o_disp_load  (bus.disp_load)
    );

    assign bus.mode_sel  = r_mode_sel;
    assign bus.mode_lamp = r_lamp;
    assign bus.en_accum  = r_en_accum;
    assign bus.point     = r_point;
    assign bus.col       = r_col;

endmodule

`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
// tb_display_mode_ctrl: directed stimulus with a cycle-stamped scoreboard of
// expected levels and expected conv_start/disp_load pulses.
`default_nettype none

module tb_display_mode_ctrl;

    localparam int S_SEL   = 0;
    localparam int S_LAMP  = 1;
    localparam int S_ACC   = 2;
    localparam int S_POINT = 3;
    localparam int S_COL   = 4;
    localparam int S_START = 5;
    localparam int S_LOAD  = 6;

`ifdef DISPLAY_AUTO_SCROLL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    display_mode_ctrl_if #(.NUM_MODES(4), .SPEED_WIDTH(12)) bus ();

    display_mode_ctrl #(
        .NUM_MODES       (4),
        .SPEED_WIDTH     (12),
        .OVERSPEED_LIMIT (65),
        .STOP_LIMIT      (6),
        .COL_MODE        (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t q_lvl[$];
    int   q_start[$];
    int   q_load[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    bit   drained = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int sample(input int sig);
        case (sig)
            S_SEL:   return int'(bus.mode_sel);
            S_LAMP:  return int'(bus.mode_lamp);
            S_ACC:   return int'(bus.en_accum);
            S_POINT: return int'(bus.point);
            S_COL:   return int'(bus.col);
            S_START: return int'(bus.conv_start);
            default: return int'(bus.disp_load);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_SEL:   return "mode_sel";
            S_LAMP:  return "mode_lamp";
            S_ACC:   return "en_accum";
            S_POINT: return "point";
            S_COL:   return "col";
            S_START: return "conv_start";
            default: return "disp_load";
        endcase
    endfunction

    task automatic expect_lvl(input int sig, input int val, input int at);
        exp_t e;
        e.cyc = at;
        e.sig = sig;
        e.val = val;
        q_lvl.push_back(e);
    endtask

    task automatic expect_all_zero(input int at);
        for (int s = S_SEL; s <= S_LOAD; s++) expect_lvl(s, 0, at);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clock) begin
        while (q_start.size() > 0 && q_start[0] < cyc) begin
            checks++; failures++;
            $display("FAIL conv_start_missing cyc=%0d got=none exp_at=%0d", cyc, q_start.pop_front());
        end
        while (q_load.size() > 0 && q_load[0] < cyc) begin
            checks++; failures++;
            $display("FAIL disp_load_missing cyc=%0d got=none exp_at=%0d", cyc, q_load.pop_front());
        end
        if (bus.conv_start === 1'b1) begin
            checks++;
            if (q_start.size() == 0) begin
                failures++;
                $display("FAIL conv_start_unexpected cyc=%0d got=1 exp=0", cyc);
            end else if (q_start[0] != cyc) begin
                failures++;
                $display("FAIL conv_start_timing got_cyc=%0d exp_cyc=%0d", cyc, q_start.pop_front());
            end else begin
                void'(q_start.pop_front());
            end
        end
        if (bus.disp_load === 1'b1) begin
            checks++;
            if (q_load.size() == 0) begin
                failures++;
                $display("FAIL disp_load_unexpected cyc=%0d got=1 exp=0", cyc);
            end else if (q_load[0] != cyc) begin
                failures++;
                $display("FAIL disp_load_timing got_cyc=%0d exp_cyc=%0d", cyc, q_load.pop_front());
            end else begin
                void'(q_load.pop_front());
            end
        end
        for (int i = q_lvl.size() - 1; i >= 0; i--) begin
            if (q_lvl[i].cyc <= cyc) begin
                checks++;
                if (q_lvl[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s_stale cyc=%0d exp_at=%0d", sig_name(q_lvl[i].sig), cyc, q_lvl[i].cyc);
                end else if (sample(q_lvl[i].sig) !== q_lvl[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%0d exp=%0d", sig_name(q_lvl[i].sig), cyc,
                             sample(q_lvl[i].sig), q_lvl[i].val);
                end
                q_lvl.delete(i);
            end
        end
        if (done && !drained) begin
            drained = 1'b1;
            checks++;
            if (q_start.size() + q_load.size() + q_lvl.size() != 0) begin
                failures++;
                $display("FAIL leftover_expectations got=%0d exp=0", q_start.size() + q_load.size() + q_lvl.size());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Answer the conversion started at cycle s, 3 cycles later
    task automatic convert(input int s);
        while (cyc < s + 3) tick();
        bus.conv_valid = 1'b1;
        q_load.push_back(s + 4);
        tick();
        bus.conv_valid = 1'b0;
        tick();
    endtask

    task automatic press_mode(input int sel, input int lamp_old, input int lamp_new);
        int k;
        k = cyc;
        bus.mode = 1'b1;
        expect_lvl(S_SEL, sel, k + 1);
        expect_lvl(S_LAMP, lamp_old, k + 1);
        expect_lvl(S_LAMP, lamp_new, k + 2);
        expect_lvl(S_POINT, (sel < 2) ? 1 : 0, k + 1);
        expect_lvl(S_COL, 0, k + 1);
        q_start.push_back(k + 2);
        tick();
        bus.mode = 1'b0;
        convert(k + 2);
    endtask

    task automatic half_pulse(input int lamp);
        int h;
        h = cyc;
        bus.half_sec_pulse = 1'b1;
        expect_lvl(S_LAMP, lamp, h + 2);
        tick();
        bus.half_sec_pulse = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int k;
        bus.mode           = 1'b0;
        bus.half_sec_pulse = 1'b0;
        bus.sec_pulse      = 1'b0;
        bus.speed          = '0;
        bus.conv_valid     = 1'b0;
        reset              = 1'b1;
        tick();
        tick();
        expect_all_zero(cyc + 1);
        tick();
        reset = 1'b0;
        expect_lvl(S_LAMP, 1, cyc + 1);

        // Stop threshold
        k = cyc;
        bus.speed = 12'd5;
        expect_lvl(S_ACC, 0, k + 1);
        tick();
        bus.speed = 12'd6;
        expect_lvl(S_ACC, 0, k + 1);
        expect_lvl(S_ACC, 1, k + 2);
        tick();
        tick();

        // Mode cycling with wrap
        press_mode(1, 4'b0001, 4'b0010);
        press_mode(2, 4'b0010, 4'b0100);
        press_mode(3, 4'b0100, 4'b1000);
        press_mode(0, 4'b1000, 4'b0001);
        press_mode(1, 4'b0001, 4'b0010);

        // Overspeed blinking
        bus.speed = 12'd70;
        expect_lvl(S_LAMP, 4'b0010, cyc + 1);
        tick();
        half_pulse(4'b1111);
        half_pulse(4'b0010);
        half_pulse(4'b1111);
        half_pulse(4'b0010);
        bus.speed = 12'd65;
        half_pulse(4'b0010);

        // Merged sources, then a request pending during WAIT
        k = cyc;
        bus.sec_pulse = 1'b1;
        bus.mode      = 1'b1;
        expect_lvl(S_SEL, 2, k + 1);
        expect_lvl(S_POINT, 0, k + 1);
        expect_lvl(S_COL, 0, k + 1);
        q_start.push_back(k + 1);
        tick();
        bus.sec_pulse = 1'b0;
        bus.mode      = 1'b0;
        tick();
        tick();
        bus.sec_pulse = 1'b1;
        expect_lvl(S_COL, 1, k + 4);
        expect_lvl(S_POINT, 0, k + 4);
        tick();
        bus.sec_pulse = 1'b0;
        tick();
        bus.conv_valid = 1'b1;
        q_load.push_back(k + 6);
        q_start.push_back(k + 6);
        tick();
        bus.conv_valid = 1'b0;
        convert(k + 6);

        // Stray conv_valid while idle
        k = cyc;
        bus.conv_valid = 1'b1;
        expect_lvl(S_LOAD, 0, k + 1);
        expect_lvl(S_START, 0, k + 1);
        tick();
        bus.conv_valid = 1'b0;
        tick();
        tick();

        // Five seconds without a mode pulse
        press_mode(3, 4'b0100, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            k = cyc;
            bus.sec_pulse = 1'b1;
            expect_lvl(S_SEL, (i == 4 && AUTO) ? 0 : 3, k + 1);
            expect_lvl(S_POINT, (i == 4 && AUTO) ? 1 : 0, k + 1);
            q_start.push_back(k + 1);
            tick();
            bus.sec_pulse = 1'b0;
            convert(k + 1);
        end

        // Reset arriving mid-WAIT together with conv_valid
        k = cyc;
        bus.sec_pulse = 1'b1;
        q_start.push_back(k + 1);
        tick();
        bus.sec_pulse = 1'b0;
        tick();
        tick();
        expect_lvl(S_ACC, 1, k + 3);
        expect_lvl(S_LAMP, AUTO ? 4'b0001 : 4'b1000, k + 3);
        reset          = 1'b1;
        bus.conv_valid = 1'b1;
        expect_all_zero(k + 4);
        tick();
        reset          = 1'b0;
        bus.conv_valid = 1'b0;
        tick();
        tick();

        // First second after reset issues a request
        k = cyc;
        bus.sec_pulse = 1'b1;
        expect_lvl(S_SEL, 0, k + 1);
        expect_lvl(S_POINT, 1, k + 1);
        q_start.push_back(k + 1);
        tick();
        bus.sec_pulse = 1'b0;
        convert(k + 1);

        repeat (3) tick();
        done = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
